axis_frame_length_limit: RTL and testbench



---
 rtl/axis_frame_length_limit.sv | 203 ++++++++++++++++++++
 tb/tb_axis_frame_length_limit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_length_limit.sv
// axis_frame_length_limit
//
// AXI-stream frame conditioner with a single output register stage. Frames shorter than the
// minimum are padded with zero beats. Frames longer than the maximum are cut at the maximum,
// flagged on tuser, and the rest of the input frame is discarded. Each completed output frame
// produces a one-cycle status pulse that carries the final length and the path taken.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   input_axis_*                input stream (tdata/tvalid/tready/tlast/tuser)
//   output_axis_*               output stream (tdata/tvalid/tready/tlast/tuser)
//   length_min                  minimum output beats (0 or 1 disables padding)
//   length_max                  maximum output beats (0 disables truncation)
//   status_valid                one-cycle pulse per completed output frame
//   status_padded/_truncated    path taken by the reported frame
//   status_length               reported frame length in beats

module axis_frame_length_limit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,

    input  logic [LEN_WIDTH-1:0]  length_min,
    input  logic [LEN_WIDTH-1:0]  length_max,

    output logic                  status_valid,
    output logic                  status_padded,
    output logic                  status_truncated,
    output logic [LEN_WIDTH-1:0]  status_length
);

    typedef enum logic [1:0] {StTransfer, StPad, StTruncate} state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  min_q, min_d;
    logic [LEN_WIDTH-1:0]  max_q, max_d;
    logic                  pad_user_q, pad_user_d;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  out_user_q, out_user_d;

    logic                  st_valid_q, st_valid_d;
    logic                  st_padded_q, st_padded_d;
    logic                  st_trunc_q, st_trunc_d;
    logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;

    logic                  slot_free;
    logic                  first_beat;
    logic                  in_ready;
    logic [LEN_WIDTH-1:0]  eff_min, eff_max, pad_tgt, cnt_inc;

    always_comb begin
        slot_free  = !out_valid_q || output_axis_tready;
        // Counter is zero only between frames, so the first beat uses the live limit inputs.
        first_beat = (state_q == StTransfer) && (cnt_q == '0);
        eff_min    = first_beat ? length_min : min_q;
        eff_max    = first_beat ? length_max : max_q;
        pad_tgt    = ((eff_max != '0) && (eff_min > eff_max)) ? eff_max : eff_min;
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + LEN_WIDTH'(1);

        state_d     = state_q;
        cnt_d       = cnt_q;
        min_d       = min_q;
        max_d       = max_q;
        pad_user_d  = pad_user_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !output_axis_tready;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        st_valid_d  = 1'b0;
        st_padded_d = st_padded_q;
        st_trunc_d  = st_trunc_q;
        st_len_d    = st_len_q;
        in_ready    = 1'b0;

        unique case (state_q)
            StTransfer: begin
                in_ready = slot_free;
                if (input_axis_tvalid && slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = input_axis_tdata;
                    out_last_d  = 1'b0;
                    out_user_d  = 1'b0;
                    cnt_d       = cnt_inc;
                    if (first_beat) begin
                        min_d = length_min;
                        max_d = length_max;
                    end
                    if (input_axis_tlast) begin
                        if (cnt_inc >= pad_tgt) begin
                            out_last_d  = 1'b1;
                            out_user_d  = input_axis_tuser;
                            cnt_d       = '0;
                            st_valid_d  = 1'b1;
                            st_padded_d = 1'b0;
                            st_trunc_d  = 1'b0;
                            st_len_d    = cnt_inc;
                        end else begin
                            pad_user_d = input_axis_tuser;
                            state_d    = StPad;
                        end
                    end else if ((eff_max != '0) && (cnt_inc == eff_max)) begin
                        out_last_d  = 1'b1;
                        out_user_d  = 1'b1;
                        cnt_d       = '0;
                        st_valid_d  = 1'b1;
                        st_padded_d = 1'b0;
                        st_trunc_d  = 1'b1;
                        st_len_d    = cnt_inc;
                        state_d     = StTruncate;
                    end
                end
            end
            StPad: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                    out_user_d  = 1'b0;
                    cnt_d       = cnt_inc;
                    if (cnt_inc >= pad_tgt) begin
                        out_last_d  = 1'b1;
                        out_user_d  = pad_user_q;
                        cnt_d       = '0;
                        st_valid_d  = 1'b1;
                        st_padded_d = 1'b1;
                        st_trunc_d  = 1'b0;
                        st_len_d    = cnt_inc;
                        state_d     = StTransfer;
                    end
                end
            end
            StTruncate: begin
                // Drain the remainder of the oversized frame without producing output.
                in_ready = 1'b1;
                if (input_axis_tvalid && input_axis_tlast) begin
                    state_d = StTransfer;
                end
            end
            default: state_d = StTransfer;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StTransfer;
            cnt_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            pad_user_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            st_valid_q  <= 1'b0;
            st_padded_q <= 1'b0;
            st_trunc_q  <= 1'b0;
            st_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            pad_user_q  <= pad_user_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            st_valid_q  <= st_valid_d;
            st_padded_q <= st_padded_d;
            st_trunc_q  <= st_trunc_d;
            st_len_q    <= st_len_d;
        end
    end

    assign input_axis_tready  = in_ready && !rst;
    assign output_axis_tdata  = out_data_q;
    assign output_axis_tvalid = out_valid_q;
    assign output_axis_tlast  = out_last_q;
    assign output_axis_tuser  = out_user_q;
    assign status_valid       = st_valid_q;
    assign status_padded      = st_padded_q;
    assign status_truncated   = st_trunc_q;
    assign status_length      = st_len_q;

endmodule

// File: tb/tb_axis_frame_length_limit.sv
// Directed bench for axis_frame_length_limit: padding, truncation, backpressure, reset and
// limit-latching cases, with hand-computed expected beats and status fields.

module tb_axis_frame_length_limit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  input_axis_tdata;
    logic        input_axis_tvalid;
    logic        input_axis_tready;
    logic        input_axis_tlast;
    logic        input_axis_tuser;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready;
    logic        output_axis_tlast;
    logic        output_axis_tuser;
    logic [15:0] length_min;
    logic [15:0] length_max;
    logic        status_valid;
    logic        status_padded;
    logic        status_truncated;
    logic [15:0] status_length;

    always #5 clk = ~clk;

    axis_frame_length_limit #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .input_axis_tlast   (input_axis_tlast),
        .input_axis_tuser   (input_axis_tuser),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .output_axis_tlast  (output_axis_tlast),
        .output_axis_tuser  (output_axis_tuser),
        .length_min         (length_min),
        .length_max         (length_max),
        .status_valid       (status_valid),
        .status_padded      (status_padded),
        .status_truncated   (status_truncated),
        .status_length      (status_length)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, a valid&ready pair here is a transfer at the
    // next rising edge.
    logic [7:0] rx_data[$];
    logic       rx_last[$];
    logic       rx_user[$];
    int         status_cnt = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         toggle_mode = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold) begin
                check_eq("hold_valid", 32'(output_axis_tvalid), 32'd1);
                check_eq("hold_data", 32'(output_axis_tdata), 32'(prev_data));
                check_eq("hold_last", 32'(output_axis_tlast), 32'(prev_last));
            end
            if (output_axis_tvalid && output_axis_tready) begin
                rx_data.push_back(output_axis_tdata);
                rx_last.push_back(output_axis_tlast);
                rx_user.push_back(output_axis_tuser);
            end
            if (status_valid) status_cnt++;
            prev_hold = output_axis_tvalid && !output_axis_tready;
            prev_data = output_axis_tdata;
            prev_last = output_axis_tlast;
        end else begin
            prev_hold = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        output_axis_tready = toggle_mode ? ~output_axis_tready : 1'b1;
    end

    logic [7:0] tx[$];
    logic [7:0] exp_q[$];

    // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
    task automatic send_frame(input int n, input logic user, input bit with_last,
                              input bit clear_limits, output int stalls);
        bit acc;
        int guard;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            input_axis_tvalid = 1'b1;
            input_axis_tdata  = tx[i];
            input_axis_tlast  = with_last && (i == n - 1);
            input_axis_tuser  = (i == n - 1) ? user : 1'b0;
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = input_axis_tready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 200) begin
                    check_eq("send_timeout", 32'd0, 32'd1);
                    acc = 1'b1;
                    i   = n;
                end
            end
            if (clear_limits && i == 0) begin
                length_min = 16'd0;
                length_max = 16'd0;
            end
        end
        input_axis_tvalid = 1'b0;
        input_axis_tlast  = 1'b0;
        input_axis_tuser  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_status, input int exp_beats);
        int guard = 0;
        while ((status_cnt < exp_status || rx_data.size() < exp_beats) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) check_eq({name, "_timeout"}, 32'd0, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string name, input logic exp_user, input logic exp_pad,
                               input logic exp_trunc, input int base_status);
        int n = exp_q.size();
        check_eq({name, "_beats"}, 32'(rx_data.size()), 32'(n));
        check_eq({name, "_status_cnt"}, 32'(status_cnt - base_status), 32'd1);
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            check_eq($sformatf("%s_data%0d", name, i), 32'(rx_data[i]), 32'(exp_q[i]));
            check_eq($sformatf("%s_last%0d", name, i), 32'(rx_last[i]), 32'(i == n - 1));
            check_eq($sformatf("%s_user%0d", name, i), 32'(rx_user[i]),
                     (i == n - 1) ? 32'(exp_user) : 32'd0);
        end
        check_eq({name, "_st_len"}, 32'(status_length), 32'(n));
        check_eq({name, "_st_pad"}, 32'(status_padded), 32'(exp_pad));
        check_eq({name, "_st_trunc"}, 32'(status_truncated), 32'(exp_trunc));
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_user.delete();
        tx.delete();
        exp_q.delete();
    endtask

    int stalls;
    int base;

    initial begin
        rst                = 1'b1;
        input_axis_tdata   = '0;
        input_axis_tvalid  = 1'b0;
        input_axis_tlast   = 1'b0;
        input_axis_tuser   = 1'b0;
        output_axis_tready = 1'b1;
        length_min         = '0;
        length_max         = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(input_axis_tready), 32'd0);
        check_eq("rst_out_valid", 32'(output_axis_tvalid), 32'd0);
        check_eq("rst_out_data", 32'(output_axis_tdata), 32'd0);
        check_eq("rst_out_last", 32'(output_axis_tlast), 32'd0);
        check_eq("rst_out_user", 32'(output_axis_tuser), 32'd0);
        check_eq("rst_st_valid", 32'(status_valid), 32'd0);
        check_eq("rst_st_pad", 32'(status_padded), 32'd0);
        check_eq("rst_st_trunc", 32'(status_truncated), 32'd0);
        check_eq("rst_st_len", 32'(status_length), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame longer than the minimum passes unchanged.
        clear_rx();
        base = status_cnt;
        length_min = 16'd4;
        length_max = 16'd0;
        for (int i = 0; i < 6; i++) tx.push_back(8'(8'h01 + i));
        exp_q = tx;
        send_frame(6, 1'b0, 1'b1, 1'b0, stalls);
        wait_done("pass", base + 1, 6);
        check_frame("pass", 1'b0, 1'b0, 1'b0, base);

        // Short bad frame padded with zeros; tuser carried to the final pad beat.
        clear_rx();
        base = status_cnt;
        length_min = 16'd5;
        length_max = 16'd0;
        tx.push_back(8'hAA);
        tx.push_back(8'hBB);
        exp_q = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00};
        send_frame(2, 1'b1, 1'b1, 1'b0, stalls);
        wait_done("pad", base + 1, 5);
        check_frame("pad", 1'b1, 1'b1, 1'b0, base);

        // Truncation at 3; limits cleared after the first beat must not matter.
        clear_rx();
        base = status_cnt;
        length_min = 16'd0;
        length_max = 16'd3;
        for (int i = 0; i < 7; i++) tx.push_back(8'(8'h10 + i));
        exp_q = '{8'h10, 8'h11, 8'h12};
        send_frame(7, 1'b0, 1'b1, 1'b1, stalls);
        check_eq("trunc_drop_stalls", 32'(stalls), 32'd0);
        wait_done("trunc", base + 1, 3);
        check_frame("trunc", 1'b1, 1'b0, 1'b1, base);

        // First case again with downstream backpressure toggling.
        clear_rx();
        base = status_cnt;
        length_min = 16'd4;
        length_max = 16'd0;
        toggle_mode = 1'b1;
        for (int i = 0; i < 6; i++) tx.push_back(8'(8'h01 + i));
        exp_q = tx;
        send_frame(6, 1'b0, 1'b1, 1'b0, stalls);
        wait_done("bp", base + 1, 6);
        toggle_mode = 1'b0;
        @(posedge clk);
        #1;
        check_frame("bp", 1'b0, 1'b0, 1'b0, base);

        // Reset after beat 2 of an 8-beat frame.
        clear_rx();
        base = status_cnt;
        length_min = 16'd0;
        length_max = 16'd0;
        tx.push_back(8'h31);
        tx.push_back(8'h32);
        send_frame(2, 1'b0, 1'b0, 1'b0, stalls);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_in_ready", 32'(input_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(output_axis_tvalid), 32'd0);
        check_eq("mid_rst_st_len", 32'(status_length), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("mid_rst_no_status", 32'(status_cnt - base), 32'd0);
        @(posedge clk);
        #1;
        clear_rx();
        base = status_cnt;
        tx = '{8'h41, 8'h42, 8'h43};
        exp_q = tx;
        send_frame(3, 1'b0, 1'b1, 1'b0, stalls);
        wait_done("after_rst", base + 1, 3);
        check_frame("after_rst", 1'b0, 1'b0, 1'b0, base);

        // min > max: pad target becomes max.
        clear_rx();
        base = status_cnt;
        length_min = 16'd9;
        length_max = 16'd4;
        tx.push_back(8'h5A);
        exp_q = '{8'h5A, 8'h00, 8'h00, 8'h00};
        send_frame(1, 1'b0, 1'b1, 1'b0, stalls);
        wait_done("minmax", base + 1, 4);
        check_frame("minmax", 1'b0, 1'b1, 1'b0, base);

        // Frame of exactly length_max beats is not truncated.
        clear_rx();
        base = status_cnt;
        length_min = 16'd0;
        length_max = 16'd3;
        tx = '{8'h61, 8'h62, 8'h63};
        exp_q = tx;
        send_frame(3, 1'b0, 1'b1, 1'b0, stalls);
        wait_done("exact_max", base + 1, 3);
        check_frame("exact_max", 1'b0, 1'b0, 1'b0, base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
